// File: rtl/memtest_mem_access.sv
// Memory access engine for the memory test controllers.
// Converts single write/read requests into a req/ack handshake on a
// generic memory port, returns completion pulses and read data, and
// abandons an access when the memory fails to acknowledge in time.
module memtest_mem_access #(
   parameter int DATUM_WIDTH    = 8,
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   i_clk,
   input  logic                   i_rst_async,
   input  logic                   i_wr_req,
   input  logic                   i_rd_req,
   input  logic [ADDR_WIDTH-1:0]  i_addr,
   input  logic [DATUM_WIDTH-1:0] i_wdata,
   output logic                   o_memory_write_ready,
   output logic                   o_memory_read_valid,
   output logic [DATUM_WIDTH-1:0] o_rdata,
   output logic                   o_busy,
   output logic                   o_timeout,
   output logic                   o_mem_req,
   output logic                   o_mem_we,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic [DATUM_WIDTH-1:0] o_mem_wdata,
   input  logic                   i_mem_ack,
   input  logic [DATUM_WIDTH-1:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_RD_REQ  = 3'd2,
      S_WR_DONE = 3'd3,
      S_RD_DONE = 3'd4,
      S_TIMEOUT = 3'd5
   } state_t;

   // A zero limit disables the timeout; keep the counter one bit wide then
   // so the declarations stay legal.
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [DATUM_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATUM_WIDTH-1:0] rdata_q, rdata_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic                   wr_ready_q, wr_ready_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   busy_q, busy_d;
   logic                   timeout_q, timeout_d;

   // Next-state, capture and timeout-counter logic; every output is a
   // registered decode of the next state so the memory port sees clean
   // levels one cycle after each decision.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;

      case (state_q)
         S_IDLE: begin
            // Write has priority; a simultaneous read is dropped.
            if (i_wr_req) begin
               state_d     = S_WR_REQ;
               mem_addr_d  = i_addr;
               mem_wdata_d = i_wdata;
               cnt_d       = '0;
            end else if (i_rd_req) begin
               state_d     = S_RD_REQ;
               mem_addr_d  = i_addr;
               mem_wdata_d = i_wdata;
               cnt_d       = '0;
            end
         end
         S_WR_REQ, S_RD_REQ: begin
            // An ack arriving on the last allowed cycle still completes.
            if (i_mem_ack) begin
               if (state_q == S_WR_REQ) begin
                  state_d = S_WR_DONE;
               end else begin
                  state_d = S_RD_DONE;
                  rdata_d = i_mem_rdata;
               end
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               state_d = S_TIMEOUT;
            end else if (TO_EN) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WR_DONE, S_RD_DONE, S_TIMEOUT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_req_d  = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
      mem_we_d   = (state_d == S_WR_REQ);
      wr_ready_d = (state_d == S_WR_DONE);
      rd_valid_d = (state_d == S_RD_DONE);
      timeout_d  = (state_d == S_TIMEOUT);
      busy_d     = (state_d != S_IDLE);
   end

   // State and registered outputs; reset clears everything immediately,
   // which also withdraws any outstanding memory request.
   always_ff @(posedge i_clk or posedge i_rst_async) begin
      if (i_rst_async) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         wr_ready_q  <= wr_ready_d;
         rd_valid_q  <= rd_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   assign o_memory_write_ready = wr_ready_q;
   assign o_memory_read_valid  = rd_valid_q;
   assign o_rdata              = rdata_q;
   assign o_busy               = busy_q;
   assign o_timeout            = timeout_q;
   assign o_mem_req            = mem_req_q;
   assign o_mem_we             = mem_we_q;
   assign o_mem_addr           = mem_addr_q;
   assign o_mem_wdata          = mem_wdata_q;

endmodule

// File: tb/tb_memtest_mem_access.sv
// Directed bench for memtest_mem_access: a default instance for the main
// transactions and a TIMEOUT_CYCLES=4 instance for the timeout cases.
module tb_memtest_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_req = 1'b0;
   logic        rd_req = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  wdata = '0;
   logic        ack = 1'b0;
   logic [7:0]  mem_rdata = '0;

   logic        wr_ready, rd_valid, busy, timeout, mem_req, mem_we;
   logic [7:0]  rdata, mem_wdata;
   logic [15:0] mem_addr;

   logic        t_wr_ready, t_rd_valid, t_busy, t_timeout, t_mem_req, t_mem_we;
   logic [7:0]  t_rdata, t_mem_wdata;
   logic [15:0] t_mem_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memtest_mem_access dut (
      .i_clk(clk), .i_rst_async(rst), .i_wr_req(wr_req), .i_rd_req(rd_req),
      .i_addr(addr), .i_wdata(wdata),
      .o_memory_write_ready(wr_ready), .o_memory_read_valid(rd_valid),
      .o_rdata(rdata), .o_busy(busy), .o_timeout(timeout),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_ack(ack), .i_mem_rdata(mem_rdata)
   );

   memtest_mem_access #(.DATUM_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut_to (
      .i_clk(clk), .i_rst_async(rst), .i_wr_req(wr_req), .i_rd_req(rd_req),
      .i_addr(addr), .i_wdata(wdata),
      .o_memory_write_ready(t_wr_ready), .o_memory_read_valid(t_rd_valid),
      .o_rdata(t_rdata), .o_busy(t_busy), .o_timeout(t_timeout),
      .o_mem_req(t_mem_req), .o_mem_we(t_mem_we), .o_mem_addr(t_mem_addr),
      .o_mem_wdata(t_mem_wdata), .i_mem_ack(ack), .i_mem_rdata(mem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_req = 1'b0; rd_req = 1'b0; ack = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #1;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_req_busy got req=%0b busy=%0b want 0 0", mem_req, busy); end
      checks++; if ({wr_ready, rd_valid, timeout, mem_we} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {wr_ready, rd_valid, timeout, mem_we}); end
      checks++; if (rdata !== 8'h00 || mem_addr !== 16'h0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr, mem_wdata); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      addr = 16'h0012; wdata = 8'hA5; wr_req = 1'b1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_n got %0b want 0", busy); end
      tick(); wr_req = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wr_n1 got req=%0b we=%0b busy=%0b want 1 1 1", mem_req, mem_we, busy); end
      checks++; if (mem_addr !== 16'h0012 || mem_wdata !== 8'hA5) begin errors++; $display("FAIL wr_n1_bus got addr=%h wdata=%h want 0012 a5", mem_addr, mem_wdata); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_n1 got %0b want 0", wr_ready); end
      ack = 1'b1;
      tick(); ack = 1'b0;
      checks++; if (wr_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_n2 got rdy=%0b req=%0b we=%0b busy=%0b want 1 0 0 1", wr_ready, mem_req, mem_we, busy); end
      tick();
      checks++; if (wr_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_n3 got rdy=%0b busy=%0b want 0 0", wr_ready, busy); end
   endtask

   task automatic test_read();
      addr = 16'h0012; rd_req = 1'b1;
      tick(); rd_req = 1'b0;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_we got %0b want 0", mem_we); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (mem_req !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rd_wait%0d got req=%0b vld=%0b want 1 0", i, mem_req, rd_valid); end
         tick();
      end
      ack = 1'b1; mem_rdata = 8'h5A;
      tick(); ack = 1'b0; mem_rdata = 8'hFF;
      checks++; if (rd_valid !== 1'b1 || rdata !== 8'h5A || mem_req !== 1'b0) begin errors++; $display("FAIL rd_done got vld=%0b rdata=%h req=%0b want 1 5a 0", rd_valid, rdata, mem_req); end
      tick();
      checks++; if (rd_valid !== 1'b0 || rdata !== 8'h5A || busy !== 1'b0) begin errors++; $display("FAIL rd_hold got vld=%0b rdata=%h busy=%0b want 0 5a 0", rd_valid, rdata, busy); end
      tick();
      checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rd_hold2 got %h want 5a", rdata); end
   endtask

   task automatic test_async_reset();
      addr = 16'h0012; rd_req = 1'b1;
      tick(); rd_req = 1'b0;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ar_req_before got %0b want 1", mem_req); end
      #2 rst = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL ar_immediate got req=%0b busy=%0b we=%0b want 0 0 0", mem_req, busy, mem_we); end
      checks++; if (rdata !== 8'h00 || mem_addr !== 16'h0) begin errors++; $display("FAIL ar_data got rdata=%h addr=%h want 00 0000", rdata, mem_addr); end
      tick();
      checks++; if ({rd_valid, wr_ready, timeout, mem_req} !== 4'b0) begin errors++; $display("FAIL ar_held got %b want 0000", {rd_valid, wr_ready, timeout, mem_req}); end
      rst = 1'b0;
      addr = 16'h0021; wdata = 8'hC3; wr_req = 1'b1;
      tick(); wr_req = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0021 || mem_wdata !== 8'hC3) begin errors++; $display("FAIL ar_wr_req got req=%0b we=%0b addr=%h wdata=%h want 1 1 0021 c3", mem_req, mem_we, mem_addr, mem_wdata); end
      ack = 1'b1;
      tick(); ack = 1'b0;
      checks++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL ar_wr_done got rdy=%0b vld=%0b to=%0b want 1 0 0", wr_ready, rd_valid, timeout); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_idle got busy=%0b want 0", busy); end
   endtask

   task automatic test_both_requests();
      addr = 16'h0034; wdata = 8'h77; wr_req = 1'b1; rd_req = 1'b1;
      tick(); wr_req = 1'b0; rd_req = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0034 || mem_wdata !== 8'h77) begin errors++; $display("FAIL both_req got req=%0b we=%0b addr=%h wdata=%h want 1 1 0034 77", mem_req, mem_we, mem_addr, mem_wdata); end
      ack = 1'b1;
      tick(); ack = 1'b0;
      checks++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL both_done got rdy=%0b vld=%0b want 1 0", wr_ready, rd_valid); end
      tick();
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL both_idle got req=%0b busy=%0b want 0 0", mem_req, busy); end
      tick();
      checks++; if (mem_req !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL both_no_read got req=%0b vld=%0b want 0 0", mem_req, rd_valid); end
   endtask

   task automatic test_back_to_back();
      addr = 16'h0056; wdata = 8'h3C; wr_req = 1'b1; ack = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req1 got %0b want 1", mem_req); end
      tick();
      checks++; if (wr_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_done1 got rdy=%0b req=%0b want 1 0", wr_ready, mem_req); end
      tick();
      checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%0b req=%0b rdy=%0b want 0 0 0", busy, mem_req, wr_ready); end
      tick(); wr_req = 1'b0;
      checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_req2 got req=%0b busy=%0b want 1 1", mem_req, busy); end
      tick(); ack = 1'b0;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %0b want 1", wr_ready); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end got busy=%0b want 0", busy); end
   endtask

   task automatic test_timeout();
      do_reset();
      addr = 16'h0099; rd_req = 1'b1;
      tick(); rd_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (t_mem_req !== 1'b1 || t_timeout !== 1'b0) begin errors++; $display("FAIL to_wait%0d got req=%0b to=%0b want 1 0", i, t_mem_req, t_timeout); end
         tick();
      end
      checks++; if (t_timeout !== 1'b1 || t_mem_req !== 1'b0 || t_rd_valid !== 1'b0 || t_busy !== 1'b1) begin errors++; $display("FAIL to_pulse got to=%0b req=%0b vld=%0b busy=%0b want 1 0 0 1", t_timeout, t_mem_req, t_rd_valid, t_busy); end
      tick();
      checks++; if (t_timeout !== 1'b0 || t_busy !== 1'b0 || t_rd_valid !== 1'b0 || t_wr_ready !== 1'b0) begin errors++; $display("FAIL to_after got to=%0b busy=%0b vld=%0b rdy=%0b want 0 0 0 0", t_timeout, t_busy, t_rd_valid, t_wr_ready); end
   endtask

   task automatic test_timeout_last_ack();
      do_reset();
      addr = 16'h00AA; wdata = 8'h11; wr_req = 1'b1;
      tick(); wr_req = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (t_mem_req !== 1'b1) begin errors++; $display("FAIL tol_req4 got %0b want 1", t_mem_req); end
      ack = 1'b1;
      tick(); ack = 1'b0;
      checks++; if (t_wr_ready !== 1'b1 || t_timeout !== 1'b0) begin errors++; $display("FAIL tol_done got rdy=%0b to=%0b want 1 0", t_wr_ready, t_timeout); end
      tick();
      checks++; if (t_timeout !== 1'b0 || t_busy !== 1'b0) begin errors++; $display("FAIL tol_after got to=%0b busy=%0b want 0 0", t_timeout, t_busy); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_async_reset();
      test_both_requests();
      test_back_to_back();
      test_timeout();
      test_timeout_last_ack();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
